m_ifetch: RTL and testbench

Instruction-fetch stage for the 5-stage MIPS-subset pipeline. It owns the fetch PC, drives the synchronous instruction memory, and delivers one instruction per cycle to the ID stage. A 2-entry fetch queue absorbs the memory's 1-cycle read latency, so a decode stall never drops an in-flight word. Taken-branch redirects squash all younger fetched words.

---
 rtl/m_ifetch_pkg.sv | 30 +++
 rtl/m_ifetch_fetchq.sv | 55 +++++
 rtl/m_ifetch.sv | 117 +++++++++++
 tb/tb_m_ifetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/m_ifetch_pkg.sv
// Shared definitions for the fetch stage: opcodes, NOP word, queue entry type.
package m_ifetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned QCNT_W = 2;

    // Primary opcodes of the supported MIPS subset
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // add $0,$0,$0
    localparam logic [XLEN-1:0] NOP_WORD     = {21'h0, 11'h20};
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/m_ifetch_fetchq.sv
// Two-entry fetch queue; the head is a plain register so it can drive ID directly.
module m_fetchq
    import m_ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_flush,
    input  logic              w_push,
    input  logic              w_pop,
    input  fq_entry_t         w_din,
    output fq_entry_t         r_head,
    output logic [QCNT_W-1:0] r_count
);

    fq_entry_t r_tail;

    // Queue storage and occupancy; flush discards everything including a same-cycle push
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) r_head <= w_din;
                    else               r_tail <= w_din;
                    r_count <= r_count + QCNT_W'(1);
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - QCNT_W'(1);
                end
                2'b11: begin
                    if (r_count == QCNT_W'(1)) begin
                        r_head <= w_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_din;
                    end
                end
                default: ;
            endcase
        end
    end

    // The issue throttle must guarantee a push never lands on a full queue
    a_no_overflow: assert property (@(posedge w_clk) disable iff (w_rst)
        !(w_push && !w_pop && !w_flush && (r_count == QCNT_W'(DEPTH))));

endmodule

// File: rtl/m_ifetch.sv
// Instruction fetch: owns the fetch PC, drives synchronous imem, feeds ID through a 2-entry queue.
module m_ifetch
    import m_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_stall,
    input  logic              w_taken,
    input  logic [31:0]       w_tpc,
    input  logic              w_halt,
    output logic              w_imem_en,
    output logic [ADDR_W-1:0] w_imem_addr,
    input  logic [31:0]       w_imem_dout,
    output logic              r_valid,
    output logic [31:0]       r_ir,
    output logic [31:0]       r_pc,
    output logic [31:0]       r_pc4
);

    logic [31:0]       r_fpc;
    logic [31:0]       r_if_pc;
    logic              r_epoch;
    logic              r_inflight;
    logic              r_if_epoch;

    logic              taken_c;
    logic              cons_c;
    logic              issue_c;
    logic              flush_c;
    logic              push_c;
    logic              pop_c;
    fq_entry_t         push_data_c;
    fq_entry_t         q_head;
    logic [QCNT_W-1:0] q_count;

    // Consume/issue/flush decisions and output muxing
    always_comb begin
        r_valid     = 1'b0;
        taken_c     = 1'b0;
        cons_c      = 1'b0;
        flush_c     = 1'b0;
        issue_c     = 1'b0;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        push_data_c = '0;
        r_ir        = NOP_WORD;
        r_pc        = '0;
        r_pc4       = '0;

        r_valid = (q_count != '0);
        // A redirect only means something while a branch word is on the output
        taken_c = r_valid & w_taken & ~w_halt;
        cons_c  = (r_valid & ~w_stall & ~w_halt) | taken_c;
        flush_c = w_halt | taken_c;
        // Keep queued + in-flight words within two after this cycle's consume
        issue_c = ~w_halt & ~w_rst & ~taken_c &
                  ((3'(q_count) + 3'(r_inflight)) <= (3'd1 + 3'(cons_c)));
        // Responses from before a redirect/halt carry a stale epoch and are dropped
        push_c  = r_inflight & (r_if_epoch == r_epoch) & ~flush_c;
        pop_c   = cons_c & ~flush_c;
        push_data_c.ir = w_imem_dout;
        push_data_c.pc = r_if_pc;

        if (r_valid) begin
            r_ir  = q_head.ir;
            r_pc  = q_head.pc;
            r_pc4 = pc_plus4(q_head.pc);
        end
    end

    assign w_imem_en   = issue_c;
    assign w_imem_addr = r_fpc[ADDR_W+1:2];

    // Fetch PC, epoch and in-flight request tracking
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_fpc      <= RESET_PC;
            r_epoch    <= 1'b0;
            r_inflight <= 1'b0;
            r_if_pc    <= '0;
            r_if_epoch <= 1'b0;
        end else begin
            r_inflight <= issue_c;
            if (issue_c) begin
                r_if_pc    <= r_fpc;
                r_if_epoch <= r_epoch;
            end
            if (w_halt) begin
                r_fpc   <= RESET_PC;
                r_epoch <= ~r_epoch;
            end else if (taken_c) begin
                r_fpc   <= w_tpc;
                r_epoch <= ~r_epoch;
            end else if (issue_c) begin
                r_fpc   <= pc_plus4(r_fpc);
            end
        end
    end

    m_fetchq #(
        .DEPTH (DEPTH)
    ) u_fetchq (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .w_flush (flush_c),
        .w_push  (push_c),
        .w_pop   (pop_c),
        .w_din   (push_data_c),
        .r_head  (q_head),
        .r_count (q_count)
    );

endmodule

// File: tb/tb_m_ifetch.sv
// Self-checking bench for m_ifetch: program-order reference model plus scoreboard monitor.
module tb_m_ifetch;
    import m_ifetch_pkg::*;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned MEM_WORDS = 1 << ADDR_W;

    logic              w_clk = 1'b0;
    logic              w_rst = 1'b1;
    logic              w_stall = 1'b0;
    logic              w_taken = 1'b0;
    logic [31:0]       w_tpc = '0;
    logic              w_halt = 1'b0;
    logic              w_imem_en;
    logic [ADDR_W-1:0] w_imem_addr;
    logic [31:0]       w_imem_dout = '0;
    logic              r_valid;
    logic [31:0]       r_ir;
    logic [31:0]       r_pc;
    logic [31:0]       r_pc4;

    m_ifetch #(
        .RESET_PC (32'h0),
        .ADDR_W   (ADDR_W),
        .DEPTH    (2)
    ) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_stall     (w_stall),
        .w_taken     (w_taken),
        .w_tpc       (w_tpc),
        .w_halt      (w_halt),
        .w_imem_en   (w_imem_en),
        .w_imem_addr (w_imem_addr),
        .w_imem_dout (w_imem_dout),
        .r_valid     (r_valid),
        .r_ir        (r_ir),
        .r_pc        (r_pc),
        .r_pc4       (r_pc4)
    );

    always #5 w_clk = ~w_clk;

    // Synchronous instruction memory, one-cycle read latency
    logic [31:0] imem [MEM_WORDS];
    always @(posedge w_clk) if (w_imem_en) w_imem_dout <= imem[w_imem_addr];

    int          n_cmp = 0;
    int          n_err = 0;
    int          idle = 0;
    int          consumed = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_ir(input logic [31:0] pc);
        logic [ADDR_W-1:0] ix;
        ix = pc[ADDR_W+1:2];
        return imem[ix];
    endfunction

    // Architectural restart: the next delivered word is the reset PC
    task automatic model_restart();
        exp_q.delete();
        model_last = 32'h0;
        exp_q.push_back(model_last);
    endtask

    // Drive one cycle of ID behaviour and record which word must follow in program order
    task automatic step(input logic st, input logic tk, input logic [31:0] tp, input logic hl);
        w_stall = st;
        w_taken = tk;
        w_tpc   = tp;
        w_halt  = hl;
        if (hl) begin
            model_restart();
        end else if (r_valid && (tk || !st)) begin
            model_last = tk ? tp : model_last + 32'd4;
            exp_q.push_back(model_last);
            consumed++;
        end
        @(posedge w_clk);
        #1;
    endtask

    // Monitor: every presented word must be the next program-order word; bubbles are exactly 2
    always @(negedge w_clk) begin
        if (w_rst || w_halt) begin
            idle = 0;
        end else if (!r_valid) begin
            idle++;
            chk("nop_when_invalid", r_ir, NOP_WORD);
            if (idle == 5) chk("stuck_invalid", 32'(idle), 32'd4);
        end else begin
            if (idle != 0) chk("bubble_len", 32'(idle), 32'd2);
            idle = 0;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got pc %h, expected none", r_pc);
            end else begin
                chk("pc", r_pc, exp_q[0]);
                chk("ir", r_ir, exp_ir(exp_q[0]));
                chk("pc4", r_pc4, exp_q[0] + 32'd4);
                if (w_taken || !w_stall) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(r_valid), 32'd0);
        chk({tag, "_ir"}, r_ir, NOP_WORD);
        chk({tag, "_pc"}, r_pc, 32'h0);
        chk({tag, "_pc4"}, r_pc4, 32'h0);
        chk({tag, "_imem_en"}, 32'(w_imem_en), 32'd0);
    endtask

    // Release reset just after an edge and check the two-edge cold-start latency
    task automatic cold_start();
        w_rst = 1'b0;
        #1;
        chk("cold_en", 32'(w_imem_en), 32'd1);
        chk("cold_addr", 32'(w_imem_addr), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("cold_valid_e1", 32'(r_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("cold_valid_e2", 32'(r_valid), 32'd1);
        chk("cold_pc", r_pc, 32'h0);
    endtask

    initial begin
        logic [31:0] tp;
        int          r;

        for (int i = 0; i < int'(MEM_WORDS); i++) imem[i] = $urandom();
        imem[0] = NOP_WORD;
        imem[1] = {OP_ADDI, 5'd0, 5'd1, 16'd1};
        imem[2] = {OP_ADDI, 5'd0, 5'd2, 16'd2};
        imem[3] = {OP_SW, 5'd0, 5'd1, 16'h10};
        imem[8] = {OP_BNE, 5'd1, 5'd2, 16'h7};
        model_restart();

        repeat (2) @(posedge w_clk);
        #1;
        check_reset_outputs("reset");
        cold_start();

        // Steady state: one word per cycle
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq_pc4_addr", r_pc, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq_pc8_addr", r_pc, 32'h8);
        chk("seq_pc8_pc4", r_pc4, 32'hC);

        // Stall three cycles at 0x8
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_pc_1", r_pc, 32'h8);
        chk("stall_en_full", 32'(w_imem_en), 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_pc_2", r_pc, 32'h8);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_pc_3", r_pc, 32'h8);
        chk("stall_valid", 32'(r_valid), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("release_valid_c", 32'(r_valid), 32'd1);
        chk("release_pc_c", r_pc, 32'hC);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("release_valid_10", 32'(r_valid), 32'd1);
        chk("release_pc_10", r_pc, 32'h10);

        // Taken BNE at 0x20 redirecting to 0x40
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("bne_pc", r_pc, 32'h20);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        chk("redir_bubble_1", 32'(r_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_bubble_2", 32'(r_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_valid", 32'(r_valid), 32'd1);
        chk("redir_pc", r_pc, 32'h40);

        // Taken with stall in the same cycle
        step(1'b1, 1'b1, 32'h80, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("taken_stall_pc", r_pc, 32'h80);

        // Halt pulse at 0x30 with a fetch in flight
        step(1'b0, 1'b1, 32'h30, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("halt_pre_pc", r_pc, 32'h30);
        chk("halt_pre_en", 32'(w_imem_en), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("halt_valid", 32'(r_valid), 32'd0);
        chk("halt_en", 32'(w_imem_en), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("halt_bubble", 32'(r_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("halt_resume_valid", 32'(r_valid), 32'd1);
        chk("halt_resume_pc", r_pc, 32'h0);

        // Asynchronous reset between edges mid-stream
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        w_rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_restart();
        repeat (2) @(posedge w_clk);
        #1;
        cold_start();

        // Randomized ID behaviour including address and 32-bit PC wrap targets
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      tp = 32'hFFFF_FFFC;
            else if (r == 1) tp = 32'h0000_3FFC;
            else             tp = $urandom() & 32'hFFFF_FFFC;
            step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10), tp,
                 ($urandom_range(0, 99) < 3));
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("throughput", 32'(consumed >= 500), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
